// File: rtl/lbist_pkg.sv
// lbist_pkg: shared state encoding, default MISR constants and counter-width helper.
package lbist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;
  localparam logic [15:0] DEF_MISR_POLY = 16'h002D;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/lbist_misr_compactor_if.sv
// lbist_misr_compactor_if: controller/compactor bus; XMASK present only with LBIST_MISR_XMASK_EN.
interface lbist_misr_compactor_if
  import lbist_pkg::*;
#(
  parameter int IN_WIDTH       = 16,
  parameter int MISR_SIZE      = 16,
  parameter int PATTERN_NUMBER = 2000
);
  localparam int PW = cnt_width(PATTERN_NUMBER + 1);
  logic                 start;
  logic                 compact_en;
  logic [IN_WIDTH-1:0]  dut_out;
`ifdef LBIST_MISR_XMASK_EN
  logic [IN_WIDTH-1:0]  xmask;
`endif
  logic [MISR_SIZE-1:0] signature;
  logic [PW-1:0]        pattern_cnt;
  logic                 busy;
  logic                 done;
  logic                 go_nogo;
  modport master (
`ifdef LBIST_MISR_XMASK_EN
    output xmask,
`endif
    output start, compact_en, dut_out,
    input  signature, pattern_cnt, busy, done, go_nogo
  );
  modport slave (
`ifdef LBIST_MISR_XMASK_EN
    input  xmask,
`endif
    input  start, compact_en, dut_out,
    output signature, pattern_cnt, busy, done, go_nogo
  );
endinterface

// File: rtl/lbist_misr.sv
// lbist_misr: Galois-form multiple-input signature register with seed load and enable.
module lbist_misr #(
  parameter int               WIDTH    = 16,
  parameter int               IN_WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY     = '0,
  parameter logic [WIDTH-1:0] SEED     = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                en,
  input  logic [IN_WIDTH-1:0] din,
  output logic [WIDTH-1:0]    sig
);
  logic [WIDTH-1:0] nxt;
  always_comb nxt = (sig << 1) ^ ({WIDTH{sig[WIDTH-1]}} & POLY) ^ WIDTH'(din);
  always_ff @(posedge clk or posedge rst)
    if (rst) sig <= SEED;
    else if (load) sig <= SEED;
    else if (en) sig <= nxt;
endmodule

// File: rtl/lbist_misr_compactor.sv
// lbist_misr_compactor: LBIST response compactor with shift/pattern counters and golden compare.
// Define LBIST_MISR_XMASK_EN to mask unknown scan cells out of the signature.
module lbist_misr_compactor
  import lbist_pkg::*;
#(
  parameter int                   IN_WIDTH       = 16,
  parameter int                   MISR_SIZE      = 16,
  parameter logic [MISR_SIZE-1:0] MISR_POLY      = MISR_SIZE'(DEF_MISR_POLY),
  parameter logic [MISR_SIZE-1:0] MISR_SEED      = MISR_SIZE'(DEF_MISR_SEED),
  parameter logic [MISR_SIZE-1:0] MISR_GOLD      = '0,
  parameter int                   CHAIN_LENGTH   = 24,
  parameter int                   PATTERN_NUMBER = 2000
) (
  input logic CLK,
  input logic RST,
  lbist_misr_compactor_if.slave bus
);
  localparam int SW = cnt_width(CHAIN_LENGTH);
  localparam int PW = cnt_width(PATTERN_NUMBER + 1);
  state_t              state;
  logic [SW-1:0]       shift_cnt;
  logic [IN_WIDTH-1:0] din;
  logic                load, step, last_shift, last_pat;
`ifdef LBIST_MISR_XMASK_EN
  assign din = bus.dut_out & ~bus.xmask;
`else
  assign din = bus.dut_out;
`endif
  assign load       = bus.start && (state == IDLE || state == DONE);
  assign step       = (state == RUN) && bus.compact_en;
  assign last_shift = shift_cnt == SW'(CHAIN_LENGTH - 1);
  assign last_pat   = bus.pattern_cnt == PW'(PATTERN_NUMBER - 1);
  lbist_misr #(
    .WIDTH(MISR_SIZE),
    .IN_WIDTH(IN_WIDTH),
    .POLY(MISR_POLY),
    .SEED(MISR_SEED)
  ) u_misr (
    .clk(CLK),
    .rst(RST),
    .load(load),
    .en(step),
    .din(din),
    .sig(bus.signature)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state           <= IDLE;
      shift_cnt       <= '0;
      bus.pattern_cnt <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.go_nogo     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          state           <= RUN;
          shift_cnt       <= '0;
          bus.pattern_cnt <= '0;
          bus.busy        <= 1'b1;
          bus.done        <= 1'b0;
          bus.go_nogo     <= 1'b0;
        end
        RUN: if (bus.compact_en) begin
          shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
          if (last_shift) begin
            bus.pattern_cnt <= bus.pattern_cnt + 1'b1;
            if (last_pat) state <= COMPARE;
          end
        end
        COMPARE: begin
          bus.go_nogo <= bus.signature == MISR_GOLD;
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= DONE;
        end
      endcase
    end
endmodule

// File: tb/tb_lbist_misr_compactor.sv
// tb_lbist_misr_compactor: directed scoreboard bench; two instances differ only in MISR_GOLD (0 and 8).
module tb_lbist_misr_compactor;
  logic CLK, RST;
  int vectors = 0;
  int errors  = 0;
  logic [3:0] sb[$];

  lbist_misr_compactor_if #(.IN_WIDTH(4), .MISR_SIZE(4), .PATTERN_NUMBER(2)) if0 ();
  lbist_misr_compactor_if #(.IN_WIDTH(4), .MISR_SIZE(4), .PATTERN_NUMBER(2)) if8 ();

  assign if8.start      = if0.start;
  assign if8.compact_en = if0.compact_en;
  assign if8.dut_out    = if0.dut_out;
`ifdef LBIST_MISR_XMASK_EN
  assign if8.xmask      = if0.xmask;
`endif

  lbist_misr_compactor #(
    .IN_WIDTH(4), .MISR_SIZE(4), .MISR_POLY(4'b0011), .MISR_SEED(4'h0),
    .MISR_GOLD(4'h0), .CHAIN_LENGTH(2), .PATTERN_NUMBER(2)
  ) dut0 (.CLK(CLK), .RST(RST), .bus(if0.slave));

  lbist_misr_compactor #(
    .IN_WIDTH(4), .MISR_SIZE(4), .MISR_POLY(4'b0011), .MISR_SEED(4'h0),
    .MISR_GOLD(4'h8), .CHAIN_LENGTH(2), .PATTERN_NUMBER(2)
  ) dut8 (.CLK(CLK), .RST(RST), .bus(if8.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    if0.start = 1'b1;
    tick();
    if0.start = 1'b0;
  endtask

  task automatic compact(input logic [3:0] d, input logic [3:0] exp);
    logic [3:0] e;
    if0.compact_en = 1'b1;
    if0.dut_out    = d;
    sb.push_back(exp);
    tick();
    if0.compact_en = 1'b0;
    if0.dut_out    = 4'h0;
    e = sb.pop_front();
    check("sig0", if0.signature, e);
    check("sig8", if8.signature, e);
  endtask

  task automatic finish_session(input logic go0, input logic go8);
    check("busy_compare", if0.busy, 1);
    check("done_compare", if0.done, 0);
    tick();
    check("done0", if0.done, 1);
    check("busy_done", if0.busy, 0);
    check("go0", if0.go_nogo, go0);
    check("done8", if8.done, 1);
    check("go8", if8.go_nogo, go8);
  endtask

  initial begin
    RST = 1'b1;
    if0.start = 1'b0;
    if0.compact_en = 1'b0;
    if0.dut_out = 4'h0;
`ifdef LBIST_MISR_XMASK_EN
    if0.xmask = 4'h0;
`endif
    tick();
    tick();
    check("rst_sig", if0.signature, 0);
    check("rst_busy", if0.busy, 0);
    check("rst_done", if0.done, 0);
    check("rst_go", if0.go_nogo, 0);
    check("rst_pcnt", if0.pattern_cnt, 0);
    RST = 1'b0;
    tick();

    if0.compact_en = 1'b1;
    if0.dut_out = 4'hF;
    tick();
    check("idle_ignore", if0.signature, 0);
    if0.compact_en = 1'b0;

    pulse_start();
    check("start_busy", if0.busy, 1);
    compact(4'h0, 4'h0);
    check("pcnt_a0", if0.pattern_cnt, 0);
    compact(4'h0, 4'h0);
    check("pcnt_a1", if0.pattern_cnt, 1);
    compact(4'h0, 4'h0);
    compact(4'h0, 4'h0);
    check("pcnt_a2", if0.pattern_cnt, 2);
    finish_session(1'b1, 1'b0);
    tick();
    check("done_hold", if0.done, 1);
    check("go_hold", if0.go_nogo, 1);

    pulse_start();
    check("restart_done", if0.done, 0);
    check("restart_go", if0.go_nogo, 0);
    check("restart_pcnt", if0.pattern_cnt, 0);
    compact(4'h1, 4'h1);
    compact(4'h0, 4'h2);
    compact(4'h0, 4'h4);
    compact(4'h0, 4'h8);
    finish_session(1'b0, 1'b1);

    pulse_start();
    compact(4'h8, 4'h8);
    compact(4'h0, 4'h3);
    compact(4'h0, 4'h6);
    compact(4'h0, 4'hC);
    finish_session(1'b0, 1'b0);

    pulse_start();
    compact(4'h5, 4'h5);
    if0.dut_out = 4'hF;
    tick();
    tick();
    check("hold_sig", if0.signature, 5);
    check("hold_pcnt", if0.pattern_cnt, 0);
    pulse_start();
    check("midrun_start_busy", if0.busy, 1);
    check("midrun_start_sig", if0.signature, 5);
    compact(4'h3, 4'h9);
    check("midrun_pcnt", if0.pattern_cnt, 1);
    compact(4'h0, 4'h1);
    #2 RST = 1'b1;
    #1;
    check("arst_sig", if0.signature, 0);
    check("arst_busy", if0.busy, 0);
    check("arst_pcnt", if0.pattern_cnt, 0);
    check("arst_done", if0.done, 0);
    #1 RST = 1'b0;
    tick();
    if0.compact_en = 1'b1;
    if0.dut_out = 4'h7;
    tick();
    check("arst_idle", if0.signature, 0);
    check("arst_idle_busy", if0.busy, 0);
    if0.compact_en = 1'b0;

`ifdef LBIST_MISR_XMASK_EN
    if0.xmask = 4'hF;
    pulse_start();
    compact(4'hF, 4'h0);
    compact(4'hF, 4'h0);
    compact(4'hF, 4'h0);
    compact(4'hF, 4'h0);
    finish_session(1'b1, 1'b0);
    if0.xmask = 4'h0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
